// File: rtl/gm_fifo_pkg.sv
// Shared helpers for the multi-VC dual-clock FIFO: pointer width and
// Gray-to-binary conversion used by the write logic, read logic and benches.
package gm_fifo_pkg;

  // Pointer width carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Gray-to-binary over a 32-bit container; bit i is the XOR of Gray bits
  // i..31, so zero-extended narrower codes convert correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gm_gray2bin.sv
// Combinational Gray-to-binary converter of a configurable width.
module gm_gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gm_mvc_write_logic.sv
// Write-domain controller for the multi-VC dual-clock FIFO. Holds one
// binary/Gray write pointer per VC, derives full / almost-full / level /
// sticky overflow against the synchronised read pointers, and produces the
// shared-RAM write address and enable.
//
// Handshake: a request is the single-cycle pulse valid_in with vc_in; there
// is no ready. The request is accepted exactly when wr_en_out is high in that
// cycle (legal VC, target not full, not in reset); otherwise it is dropped
// and the relevant sticky flag records why.
module gm_mvc_write_logic
  import gm_fifo_pkg::*;
#(
  parameter int NUM_VC          = 2,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_THR = DEPTH - 2,
  localparam int LOG2_DEPTH     = $clog2(DEPTH),
  localparam int VC_W           = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int PTR_W          = ptr_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [VC_W-1:0]            vc_in,
  output logic                       wr_en_out,
  output logic [VC_W+LOG2_DEPTH-1:0] wraddr_out,
  output logic [NUM_VC*PTR_W-1:0]    wrptr_out,
  input  logic [NUM_VC*PTR_W-1:0]    rdptr_in,
  output logic [NUM_VC-1:0]          full_out,
  output logic [NUM_VC-1:0]          almost_full_out,
  output logic [NUM_VC*PTR_W-1:0]    level_out,
  output logic [NUM_VC-1:0]          overflow_out,
  output logic                       illegal_vc_out
);

  logic [VC_W-1:0]       w_vc_sel;
  logic                  w_legal;
  logic                  w_sel_full;
  logic [LOG2_DEPTH-1:0] w_sel_low;
  logic                  w_ovf_req;
  logic [NUM_VC-1:0]     w_full;
  logic [LOG2_DEPTH-1:0] w_low [NUM_VC];
  logic                  r_illegal;

  // With a single VC the select input is ignored entirely.
  assign w_vc_sel = (NUM_VC == 1) ? '0 : vc_in;
  assign w_legal  = (NUM_VC == 1) ? 1'b1
                  : ({1'b0, vc_in} < (VC_W+1)'(NUM_VC));

  // Select the addressed VC's full flag and RAM offset without indexing
  // past the populated VCs when vc_in is out of range.
  always_comb begin
    w_sel_full = 1'b0;
    w_sel_low  = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (w_vc_sel == VC_W'(k)) begin
        w_sel_full = w_full[k];
        w_sel_low  = w_low[k];
      end
    end
  end

  assign wr_en_out  = valid_in && w_legal && !w_sel_full && !rst;
  assign w_ovf_req  = valid_in && w_legal && w_sel_full;
  assign wraddr_out = {w_vc_sel, w_sel_low};

  // Sticky record of requests aimed at a VC that does not exist.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (valid_in && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_vc_out = r_illegal;

  for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
    logic [PTR_W-1:0] r_wrbin;
    logic [PTR_W-1:0] r_wrgray;
    logic             r_ovf;
    logic [PTR_W-1:0] w_rdbin;
    logic [PTR_W-1:0] w_level;
    logic [PTR_W-1:0] w_next;
    logic             w_hit;

    gm_gray2bin #(.WIDTH(PTR_W)) u_rd_g2b (
      .i_gray (rdptr_in[k*PTR_W +: PTR_W]),
      .o_bin  (w_rdbin)
    );

    assign w_hit    = (w_vc_sel == VC_W'(k));
    assign w_next   = r_wrbin + 1'b1;
    // Modular subtraction keeps level correct across the pointer wrap.
    assign w_level  = r_wrbin - w_rdbin;
    assign w_full[k] = (r_wrbin[PTR_W-1] != w_rdbin[PTR_W-1]) &&
                       (r_wrbin[LOG2_DEPTH-1:0] == w_rdbin[LOG2_DEPTH-1:0]);
    assign w_low[k] = r_wrbin[LOG2_DEPTH-1:0];

    // Advance binary and Gray pointers together on an accepted write and
    // latch overflow when a write targets this VC while it is full.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wrbin  <= '0;
        r_wrgray <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (wr_en_out && w_hit) begin
          r_wrbin  <= w_next;
          r_wrgray <= w_next ^ (w_next >> 1);
        end
        if (w_ovf_req && w_hit) begin
          r_ovf <= 1'b1;
        end
      end
    end

    assign wrptr_out[k*PTR_W +: PTR_W] = r_wrgray;
    assign level_out[k*PTR_W +: PTR_W] = w_level;
    assign full_out[k]                 = w_full[k];
    assign almost_full_out[k]          = (w_level >= PTR_W'(ALMOST_FULL_THR));
    assign overflow_out[k]             = r_ovf;
  end

endmodule

// File: tb/tb_gm_mvc_write_logic.sv
// Directed bench for gm_mvc_write_logic: a 2-VC/depth-4 instance for fill,
// overflow, wrap and reset scenarios, and a 3-VC instance for illegal VCs.
module tb_gm_mvc_write_logic;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: NUM_VC=2, DEPTH=4, THR=3 ----------------
  logic       a_valid = 1'b0;
  logic [0:0] a_vc    = '0;
  logic [5:0] a_rdptr = '0;
  logic       a_wr_en;
  logic [2:0] a_wraddr;
  logic [5:0] a_wrptr;
  logic [1:0] a_full;
  logic [1:0] a_af;
  logic [5:0] a_level;
  logic [1:0] a_ovf;
  logic       a_ill;

  gm_mvc_write_logic #(.NUM_VC(2), .DEPTH(4), .ALMOST_FULL_THR(3)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (a_valid),
    .vc_in           (a_vc),
    .wr_en_out       (a_wr_en),
    .wraddr_out      (a_wraddr),
    .wrptr_out       (a_wrptr),
    .rdptr_in        (a_rdptr),
    .full_out        (a_full),
    .almost_full_out (a_af),
    .level_out       (a_level),
    .overflow_out    (a_ovf),
    .illegal_vc_out  (a_ill)
  );

  // ---------------- DUT B: NUM_VC=3, DEPTH=4, THR=3 ----------------
  logic       b_valid = 1'b0;
  logic [1:0] b_vc    = '0;
  logic [8:0] b_rdptr = '0;
  logic       b_wr_en;
  logic [3:0] b_wraddr;
  logic [8:0] b_wrptr;
  logic [2:0] b_full;
  logic [2:0] b_af;
  logic [8:0] b_level;
  logic [2:0] b_ovf;
  logic       b_ill;

  gm_mvc_write_logic #(.NUM_VC(3), .DEPTH(4), .ALMOST_FULL_THR(3)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (b_valid),
    .vc_in           (b_vc),
    .wr_en_out       (b_wr_en),
    .wraddr_out      (b_wraddr),
    .wrptr_out       (b_wrptr),
    .rdptr_in        (b_rdptr),
    .full_out        (b_full),
    .almost_full_out (b_af),
    .level_out       (b_level),
    .overflow_out    (b_ovf),
    .illegal_vc_out  (b_ill)
  );

  // Gray codes of 0..7, written out by hand.
  logic [2:0] gray_tab [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_valid = 1'b0; a_rdptr = '0; b_valid = 1'b0; b_rdptr = '0;
    tick();
    do_reset();
    #1;
    n_checks++;
    if (a_wrptr !== 6'd0 || a_ovf !== 2'b00 || a_ill !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a_regs: wrptr=%h ovf=%b ill=%b, want 0/00/0", a_wrptr, a_ovf, a_ill);
    end
    n_checks++;
    if (a_full !== 2'b00 || a_level !== 6'd0 || a_af !== 2'b00 || a_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a_flags: full=%b level=%h af=%b wr_en=%b, want all 0", a_full, a_level, a_af, a_wr_en);
    end
    n_checks++;
    if (b_wrptr !== 9'd0 || b_ovf !== 3'b000 || b_ill !== 1'b0 || b_level !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_b: wrptr=%h ovf=%b ill=%b level=%h, want all 0", b_wrptr, b_ovf, b_ill, b_level);
    end
  endtask

  task automatic test_fill_vc0();
    logic [2:0] exp_gray [4] = '{3'd1, 3'd3, 3'd2, 3'd6};
    logic [1:0] exp_full [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic [1:0] exp_af   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic [2:0] exp_addr [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [5:0] exp_lvl  [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_vc = 1'b0;
      #1;
      n_checks++;
      if (a_wr_en !== 1'b1 || a_wraddr !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL fill_wr %0d: wr_en=%b addr=%0d, want 1/%0d", i, a_wr_en, a_wraddr, exp_addr[i]);
      end
      tick();
      n_checks++;
      if (a_wrptr !== {3'd0, exp_gray[i]} || a_level !== exp_lvl[i] ||
          a_full !== exp_full[i] || a_af !== exp_af[i]) begin
        n_fail++;
        $display("FAIL fill_state %0d: wrptr=%h level=%h full=%b af=%b, want %h/%h/%b/%b",
                 i, a_wrptr, a_level, a_full, a_af, {3'd0, exp_gray[i]}, exp_lvl[i], exp_full[i], exp_af[i]);
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_overflow();
    a_valid = 1'b1; a_vc = 1'b0;
    #1;
    n_checks++;
    if (a_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_wr_en: wr_en=%b, want 0", a_wr_en);
    end
    tick();
    a_valid = 1'b0;
    n_checks++;
    if (a_ovf !== 2'b01 || a_wrptr !== 6'h06 || a_level !== 6'd4) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b wrptr=%h level=%h, want 01/06/04", a_ovf, a_wrptr, a_level);
    end
    tick();
    n_checks++;
    if (a_ovf !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b, want 01", a_ovf);
    end
  endtask

  task automatic test_other_vc();
    a_valid = 1'b1; a_vc = 1'b1;
    #1;
    n_checks++;
    if (a_wr_en !== 1'b1 || a_wraddr !== 3'b100) begin
      n_fail++;
      $display("FAIL vc1_wr: wr_en=%b addr=%b, want 1/100", a_wr_en, a_wraddr);
    end
    tick();
    a_valid = 1'b0;
    n_checks++;
    if (a_level !== 6'o14 || a_wrptr !== 6'o16 || a_full !== 2'b01 || a_ovf !== 2'b01) begin
      n_fail++;
      $display("FAIL vc1_state: level=%o wrptr=%o full=%b ovf=%b, want 14/16/01/01", a_level, a_wrptr, a_full, a_ovf);
    end
  endtask

  task automatic test_wrap();
    a_rdptr = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a_valid = 1'b1; a_vc = 1'b0;
      #1;
      n_checks++;
      if (a_wr_en !== 1'b1 || a_wraddr !== 3'(i % 4) || a_full[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_wr %0d: wr_en=%b addr=%0d full=%b, want 1/%0d/0", i, a_wr_en, a_wraddr, a_full[0], i % 4);
      end
      tick();
      n_checks++;
      if (a_level[2:0] !== 3'd1 || a_full[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_lvl %0d: level=%0d full=%b, want 1/0", i, a_level[2:0], a_full[0]);
      end
      a_rdptr[2:0] = gray_tab[(i + 1) % 8];
    end
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (a_wrptr[2:0] !== 3'd3 || a_level[2:0] !== 3'd0 || a_full !== 2'b00) begin
      n_fail++;
      $display("FAIL wrap_end: wrgray=%0d level=%0d full=%b, want 3/0/00", a_wrptr[2:0], a_level[2:0], a_full);
    end
  endtask

  task automatic test_illegal_vc();
    b_valid = 1'b1; b_vc = 2'd3;
    #1;
    n_checks++;
    if (b_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_wr_en: wr_en=%b, want 0", b_wr_en);
    end
    tick();
    n_checks++;
    if (b_ill !== 1'b1 || b_wrptr !== 9'd0 || b_ovf !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_state: ill=%b wrptr=%h ovf=%b, want 1/000/000", b_ill, b_wrptr, b_ovf);
    end
    b_vc = 2'd2;
    #1;
    n_checks++;
    if (b_wr_en !== 1'b1 || b_wraddr !== 4'b1000) begin
      n_fail++;
      $display("FAIL vc2_wr: wr_en=%b addr=%b, want 1/1000", b_wr_en, b_wraddr);
    end
    tick();
    b_valid = 1'b0;
    n_checks++;
    if (b_wrptr !== 9'o100 || b_ill !== 1'b1 || b_level !== 9'o100) begin
      n_fail++;
      $display("FAIL vc2_state: wrptr=%o ill=%b level=%o, want 100/1/100", b_wrptr, b_ill, b_level);
    end
  endtask

  task automatic test_reset_mid();
    a_rdptr = '0;
    do_reset();
    // Two writes to VC0, one to VC0 overflow-free, then set a VC1 overflow
    // is not possible here, so drive two writes and reset with valid high.
    a_valid = 1'b1; a_vc = 1'b0;
    tick();
    tick();
    n_checks++;
    if (a_level[2:0] !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_pre_level: level=%0d, want 2", a_level[2:0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wr_en: wr_en=%b during reset, want 0", a_wr_en);
    end
    tick();
    rst = 1'b0;
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (a_wrptr !== 6'd0 || a_level !== 6'd0 || a_full !== 2'b00 || a_af !== 2'b00 || a_ovf !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_after: wrptr=%h level=%h full=%b af=%b ovf=%b, want all 0", a_wrptr, a_level, a_full, a_af, a_ovf);
    end
    n_checks++;
    if (b_ill !== 1'b0 || b_wrptr !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_after_b: ill=%b wrptr=%h, want 0/000", b_ill, b_wrptr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_vc0();
    test_overflow();
    test_other_vc();
    test_wrap();
    test_illegal_vc();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
